// File: rtl/ksa_seq_ctrl_if.sv
// Wishbone slave bus bundle for ksa_seq_ctrl.
// Member names follow the slave's view of the bus.
interface ksa_seq_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ksa_seq_ctrl.sv
// Sequences wide adds through an external 16-bit Kogge-Stone adder.
// Optional macro KSA_SEQ_IRQ_EN adds STATUS.IRQ_EN and a registered irq_o.
module ksa_seq_ctrl #(
  parameter int MAX_SLICES = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  ksa_seq_ctrl_if.slave wbs,
  output logic [15:0]   add_a_o,
  output logic [15:0]   add_b_o,
  output logic          add_cin_o,
  input  logic [15:0]   add_sum_i,
  input  logic          add_cout_i,
  output logic          irq_o
);

  localparam int KW = (MAX_SLICES > 1) ? $clog2(MAX_SLICES) : 1;

  typedef enum logic {IDLE, ADD} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, n_m1_q, n_new;
  logic          carry_q;
  logic [63:0]   a_q, b_q, r_q;
  logic [1:0]    nsl_q, nsl_new;
  logic          cin_q, cin_new;
  logic          done_q, cout_q;
  logic          irq_en;
  logic          busy, valid, wr, cfg_wr;
  logic          start, last, w1c, st_wr;
  logic [2:0]    adr;
  logic [31:0]   rdata;
  logic          unused_ok;

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] m;
    for (int i = 0; i < 4; i++)
      m[8*i +: 8] = s[i] ? d[8*i +: 8] : o[8*i +: 8];
    return m;
  endfunction

  assign adr    = wbs.wbs_adr_i[4:2];
  assign busy   = (state_q == ADD);
  assign valid  = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~wbs.wbs_ack_o;
  assign wr     = valid & wbs.wbs_we_i;
  assign cfg_wr = wr & ~busy;
  assign st_wr  = wr && adr == 3'd1 && wbs.wbs_sel_i[0];
  assign w1c    = st_wr & wbs.wbs_dat_i[1];
  assign start  = cfg_wr && adr == 3'd0
                  && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0];
  assign last   = busy && (k_q == n_m1_q);

  assign nsl_new = wbs.wbs_sel_i[0] ? wbs.wbs_dat_i[3:2] : nsl_q;
  assign cin_new = wbs.wbs_sel_i[1] ? wbs.wbs_dat_i[8] : cin_q;
  // Requested slice count is clamped to what the datapath supports.
  assign n_new = (int'(nsl_new) >= MAX_SLICES) ?
                 KW'(MAX_SLICES - 1) : KW'(nsl_new);

  assign unused_ok = ^{wbs.wbs_adr_i[31:5], wbs.wbs_adr_i[1:0]};

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = ADD;
      ADD:  if (last)  state_d = IDLE;
    endcase
  end

  always_comb begin
    add_a_o   = '0;
    add_b_o   = '0;
    add_cin_o = 1'b0;
    if (busy) begin
      add_a_o   = a_q[16*k_q +: 16];
      add_b_o   = b_q[16*k_q +: 16];
      add_cin_o = carry_q;
    end
  end

  always_comb begin
    rdata = '0;
    case (adr)
      3'd0: rdata = {23'b0, cin_q, 4'b0, nsl_q, 2'b0};
      3'd1: rdata = {28'b0, irq_en, cout_q, done_q, busy};
      3'd2: rdata = a_q[31:0];
      3'd3: rdata = a_q[63:32];
      3'd4: rdata = b_q[31:0];
      3'd5: rdata = b_q[63:32];
      3'd6: rdata = r_q[31:0];
      3'd7: rdata = r_q[63:32];
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      k_q     <= '0;
      n_m1_q  <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      nsl_q   <= '0;
      cin_q   <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_dat_o <= '0;
    end else begin
      wbs.wbs_ack_o <= valid;
      if (valid && !wbs.wbs_we_i) wbs.wbs_dat_o <= rdata;
      if (cfg_wr) begin
        case (adr)
          3'd0: begin
            nsl_q <= nsl_new;
            cin_q <= cin_new;
          end
          3'd2: a_q[31:0]  <= merge(a_q[31:0],  wbs.wbs_dat_i, wbs.wbs_sel_i);
          3'd3: a_q[63:32] <= merge(a_q[63:32], wbs.wbs_dat_i, wbs.wbs_sel_i);
          3'd4: b_q[31:0]  <= merge(b_q[31:0],  wbs.wbs_dat_i, wbs.wbs_sel_i);
          3'd5: b_q[63:32] <= merge(b_q[63:32], wbs.wbs_dat_i, wbs.wbs_sel_i);
          default: ;
        endcase
      end
      // Clearing R up front leaves unused upper slices at zero.
      if (start) begin
        n_m1_q  <= n_new;
        k_q     <= '0;
        carry_q <= cin_new;
        r_q     <= '0;
        cout_q  <= 1'b0;
      end
      if (busy) begin
        r_q[16*k_q +: 16] <= add_sum_i;
        carry_q <= add_cout_i;
        k_q     <= k_q + 1'b1;
        if (last) cout_q <= add_cout_i;
      end
      if (last)             done_q <= 1'b1;
      else if (start | w1c) done_q <= 1'b0;
    end
  end

`ifdef KSA_SEQ_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      irq_en_q <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (st_wr) irq_en_q <= wbs.wbs_dat_i[3];
      irq_o <= done_q & irq_en_q;
    end
  end

  assign irq_en = irq_en_q;
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ksa_seq_ctrl.sv
// Directed bench for ksa_seq_ctrl with a behavioural 16-bit adder.
// Exercises KSA_SEQ_IRQ_EN paths when that macro is defined.
module tb_ksa_seq_ctrl;

  localparam logic [4:0] CTRL = 5'h00, STATUS = 5'h04;
  localparam logic [4:0] A_LO = 5'h08, A_HI = 5'h0C;
  localparam logic [4:0] B_LO = 5'h10, B_HI = 5'h14;
  localparam logic [4:0] R_LO = 5'h18, R_HI = 5'h1C;

  logic        clk;
  logic        rst_n;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout, irq;

  ksa_seq_ctrl_if bus ();

  ksa_seq_ctrl #(.MAX_SLICES(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs        (bus.slave),
    .add_a_o    (add_a),
    .add_b_o    (add_b),
    .add_cin_o  (add_cin),
    .add_sum_i  (add_sum),
    .add_cout_i (add_cout),
    .irq_o      (irq)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   act_cnt = 0;
  logic cin_log[$];

  always @(negedge clk) begin
    if (add_a != 16'h0 || add_b != 16'h0 || add_cin) begin
      act_cnt++;
      cin_log.push_back(add_cin);
    end
  end

  typedef struct {
    logic [1:0]  nm1;
    logic        cin;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        cout;
    int          cyc;
    logic [3:0]  cins;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [4:0] off,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] q, output int lat);
    bit got;
    got = 0;
    lat = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = {27'b0, off};
    bus.wbs_dat_i = d;
    bus.wbs_sel_i = s;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.wbs_ack_o) got = 1;
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    q = bus.wbs_dat_o;
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL wb_timeout: off %h no ack within 10 cycles", off);
    end
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    logic [31:0] q;
    int lat;
    xfer(1'b1, off, d, 4'hF, q, lat);
  endtask

  task automatic rd(input logic [4:0] off, output logic [31:0] q);
    int lat;
    xfer(1'b0, off, 32'h0, 4'hF, q, lat);
  endtask

  task automatic wait_idle();
    logic [31:0] q;
    bit idle;
    idle = 0;
    for (int i = 0; i < 20 && !idle; i++) begin
      rd(STATUS, q);
      if (!q[0]) idle = 1;
    end
    if (!idle) begin
      errors++;
      checks++;
      $display("FAIL busy_timeout: still busy after 20 polls");
    end
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] b);
    wr(A_LO, a[31:0]);
    wr(A_HI, a[63:32]);
    wr(B_LO, b[31:0]);
    wr(B_HI, b[63:32]);
  endtask

  initial begin
    logic [31:0] q;
    logic [3:0]  pat;
    int lat, base, lbase;

    vt[0] = '{2'd0, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1,
              64'h0, 1'b1, 1, 4'b0000};
    vt[1] = '{2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
              64'h0, 1'b1, 4, 4'b1110};
    vt[2] = '{2'd1, 1'b1, 64'h0000_1234_0000_FFFF,
              64'h0000_0001_0000_0001,
              64'h0000_0000_0001_0001, 1'b0, 2, 4'b0011};
    vt[3] = '{2'd2, 1'b0, 64'h0001_0002_0003_0004,
              64'h0010_0020_0030_0040,
              64'h0000_0022_0033_0044, 1'b0, 3, 4'b0000};
    vt[4] = '{2'd3, 1'b1, 64'h8000_8000_8000_8000,
              64'h8000_8000_8000_8000,
              64'h0001_0001_0001_0001, 1'b1, 4, 4'b1111};

    rst_n = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {63'b0, bus.wbs_ack_o}, 64'h0);
    chk("rst_dat", {32'b0, bus.wbs_dat_o}, 64'h0);
    chk("rst_irq", {63'b0, irq}, 64'h0);
    chk("rst_add", {31'b0, add_cin, add_a, add_b}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b0, STATUS, 32'h0, 4'hF, q, lat);
    chk("first_ack_lat", 64'(lat), 64'd1);
    chk("rst_status", {32'b0, q}, 64'h0);
    for (int i = 0; i < 8; i++) begin
      rd(5'(4 * i), q);
      chk($sformatf("rst_reg%0d", i), {32'b0, q}, 64'h0);
    end

    // Byte-lane gating on A_LO
    xfer(1'b1, A_LO, 32'hDEAD_BEEF, 4'b0101, q, lat);
    rd(A_LO, q);
    chk("sel_a_lo", {32'b0, q}, 64'h00AD_00EF);

    // Table-driven operations
    for (int v = 0; v < 5; v++) begin
      load(vt[v].a, vt[v].b);
      base  = act_cnt;
      lbase = cin_log.size();
      wr(CTRL, {23'b0, vt[v].cin, 4'b0, vt[v].nm1, 2'b01});
      if (vt[v].nm1 != 2'd0) begin
        rd(STATUS, q);
        chk($sformatf("v%0d_status_mid", v), {32'b0, q}, 64'h1);
      end
      wait_idle();
      rd(R_LO, q);
      chk($sformatf("v%0d_r_lo", v), {32'b0, q}, {32'b0, vt[v].r[31:0]});
      rd(R_HI, q);
      chk($sformatf("v%0d_r_hi", v), {32'b0, q}, {32'b0, vt[v].r[63:32]});
      rd(STATUS, q);
      chk($sformatf("v%0d_status", v), {32'b0, q},
          {61'b0, vt[v].cout, 2'b10});
      chk($sformatf("v%0d_busy_cycles", v), 64'(act_cnt - base),
          64'(vt[v].cyc));
      pat = 4'b0;
      for (int i = 0; i < vt[v].cyc; i++)
        if (lbase + i < cin_log.size()) pat[i] = cin_log[lbase + i];
      chk($sformatf("v%0d_cin_seq", v), {60'b0, pat}, {60'b0, vt[v].cins});
      chk($sformatf("v%0d_idle_add", v), {31'b0, add_cin, add_a, add_b},
          64'h0);
      wr(STATUS, 32'h2);
      rd(STATUS, q);
      chk($sformatf("v%0d_w1c", v), {32'b0, q}, {61'b0, vt[v].cout, 2'b00});
    end

    // Writes while busy are ignored
    load(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    wr(CTRL, 32'h0000_000D);
    wr(A_LO, 32'hDEAD_BEEF);
    wr(CTRL, 32'h0000_0001);
    wait_idle();
    rd(A_LO, q);
    chk("busy_a_lo", {32'b0, q}, 64'hFFFF_FFFF);
    rd(CTRL, q);
    chk("busy_ctrl", {32'b0, q}, 64'h0000_000C);
    rd(R_LO, q);
    chk("busy_r_lo", {32'b0, q}, 64'h0);
    rd(R_HI, q);
    chk("busy_r_hi", {32'b0, q}, 64'h0);
    rd(STATUS, q);
    chk("busy_status", {32'b0, q}, 64'h6);

    // DONE set and W1C land on the same edge
    load(64'h0000_0000_0001_0001, 64'h0000_0000_0002_0002);
    wr(CTRL, 32'h0000_0005);
    wr(STATUS, 32'h2);
    rd(STATUS, q);
    chk("done_w1c_race", {32'b0, q}, 64'h2);
    rd(R_LO, q);
    chk("race_r_lo", {32'b0, q}, 64'h0003_0003);
    wr(R_LO, 32'h1234_5678);
    rd(R_LO, q);
    chk("r_lo_ro", {32'b0, q}, 64'h0003_0003);

    // Reset in the second ADD cycle of an N=4 operation
    load(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001);
    wr(CTRL, 32'h0000_000D);
    @(posedge clk);
    #1;
    chk("mid_op_a", {48'b0, add_a}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_add", {31'b0, add_cin, add_a, add_b}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(STATUS, q);
    chk("rst_mid_status", {32'b0, q}, 64'h0);
    rd(R_LO, q);
    chk("rst_mid_r_lo", {32'b0, q}, 64'h0);
    rd(A_LO, q);
    chk("rst_mid_a_lo", {32'b0, q}, 64'h0);
    load(vt[3].a, vt[3].b);
    wr(CTRL, 32'h0000_0009);
    wait_idle();
    rd(R_LO, q);
    chk("fresh_r_lo", {32'b0, q}, {32'b0, vt[3].r[31:0]});
    rd(R_HI, q);
    chk("fresh_r_hi", {32'b0, q}, {32'b0, vt[3].r[63:32]});
    rd(STATUS, q);
    chk("fresh_status", {32'b0, q}, 64'h2);

    // Interrupt
    load(64'hFFFF, 64'h1);
`ifdef KSA_SEQ_IRQ_EN
    wr(STATUS, 32'hA);
    rd(STATUS, q);
    chk("irq_en_rd", {32'b0, q}, 64'h8);
    wr(CTRL, 32'h0000_0001);
    chk("irq_c0", {63'b0, irq}, 64'h0);
    @(posedge clk);
    #1;
    chk("irq_c1", {63'b0, irq}, 64'h0);
    @(posedge clk);
    #1;
    chk("irq_rise", {63'b0, irq}, 64'h1);
    wr(STATUS, 32'hA);
    chk("irq_hold", {63'b0, irq}, 64'h1);
    @(posedge clk);
    #1;
    chk("irq_fall", {63'b0, irq}, 64'h0);
`else
    wr(STATUS, 32'h8);
    rd(STATUS, q);
    chk("irq_en_absent", {63'b0, q[3]}, 64'h0);
    wr(CTRL, 32'h0000_0001);
    wait_idle();
    rd(STATUS, q);
    chk("irq_off_status", {32'b0, q}, 64'h6);
    chk("irq_off", {63'b0, irq}, 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
